// File: rtl/stab_window_monitor.sv
// Stabilization window monitor: after a trigger, decides whether the buffered
// sample stream stops toggling for STABLE_LEN cycles before DEADLINE expires.
module stab_window_monitor #(
  parameter int DEADLINE   = 64,
  parameter int STABLE_LEN = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             trig,
  input  logic             sig_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] last_settle,
  output logic [CNT_W-1:0] fail_cnt
);

  typedef enum logic [0:0] {IDLE = 1'b0, SETTLE = 1'b1} state_t;

  localparam logic [CNT_W-1:0] DEADLINE_C = CNT_W'(DEADLINE);
  localparam logic [CNT_W-1:0] STABLE_C   = CNT_W'(STABLE_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C     = {CNT_W{1'b0}};

  state_t           state_r, state_n_s;
  logic             sig_q_r;
  logic             toggle_s;
  logic [CNT_W-1:0] elapsed_r, stable_cnt_r;
  logic [CNT_W-1:0] elapsed_n_s, stable_n_s;
  logic             start_s, win_s, lose_s;

  logic             busy_r, done_r, pass_r;
  logic [CNT_W-1:0] last_settle_r, fail_cnt_r;
  logic             busy_n_s, done_n_s, pass_n_s;
  logic [CNT_W-1:0] last_settle_n_s, fail_cnt_n_s;

  assign toggle_s = sig_in ^ sig_q_r;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Next-state logic; an enable drop outranks any verdict on the same edge
  always_comb begin
    state_n_s   = state_r;
    start_s     = 1'b0;
    win_s       = 1'b0;
    lose_s      = 1'b0;
    elapsed_n_s = elapsed_r + ONE_C;
    if (toggle_s) begin
      stable_n_s = ZERO_C;
    end else if (stable_cnt_r >= STABLE_C) begin
      stable_n_s = STABLE_C;
    end else begin
      stable_n_s = stable_cnt_r + ONE_C;
    end
    case (state_r)
      IDLE: begin
        if (trig && en) begin
          state_n_s = SETTLE;
          start_s   = 1'b1;
        end else begin
          state_n_s = IDLE;
        end
      end
      SETTLE: begin
        if (!en) begin
          state_n_s = IDLE;
        end else if (stable_n_s == STABLE_C) begin
          state_n_s = IDLE;
          win_s     = 1'b1;
        end else if (elapsed_n_s == DEADLINE_C) begin
          state_n_s = IDLE;
          lose_s    = 1'b1;
        end else begin
          state_n_s = SETTLE;
        end
      end
      default: begin
        state_n_s = IDLE;
      end
    endcase
  end

  // Output next values, all registered below
  always_comb begin
    busy_n_s = (state_n_s == SETTLE);
    done_n_s = win_s | lose_s;
    if (win_s) begin
      pass_n_s        = 1'b1;
      last_settle_n_s = elapsed_n_s;
    end else if (lose_s) begin
      pass_n_s        = 1'b0;
      last_settle_n_s = last_settle_r;
    end else begin
      pass_n_s        = pass_r;
      last_settle_n_s = last_settle_r;
    end
    if (lose_s && (fail_cnt_r != CNT_MAX_C)) begin
      fail_cnt_n_s = fail_cnt_r + ONE_C;
    end else begin
      fail_cnt_n_s = fail_cnt_r;
    end
  end

  // Sample history and window counters
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_q_r      <= 1'b0;
      elapsed_r    <= ZERO_C;
      stable_cnt_r <= ZERO_C;
    end else begin
      sig_q_r <= sig_in;
      if (start_s) begin
        elapsed_r    <= ZERO_C;
        stable_cnt_r <= ZERO_C;
      end else if (state_r == SETTLE) begin
        elapsed_r    <= elapsed_n_s;
        stable_cnt_r <= stable_n_s;
      end else begin
        elapsed_r    <= elapsed_r;
        stable_cnt_r <= stable_cnt_r;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      pass_r        <= 1'b0;
      last_settle_r <= ZERO_C;
      fail_cnt_r    <= ZERO_C;
    end else begin
      busy_r        <= busy_n_s;
      done_r        <= done_n_s;
      pass_r        <= pass_n_s;
      last_settle_r <= last_settle_n_s;
      fail_cnt_r    <= fail_cnt_n_s;
    end
  end

  assign busy        = busy_r;
  assign done        = done_r;
  assign pass        = pass_r;
  assign last_settle = last_settle_r;
  assign fail_cnt    = fail_cnt_r;

endmodule

// File: tb/tb_stab_window_monitor.sv
// Bench for stab_window_monitor: a default instance and a CNT_W=2 instance,
// checked every cycle against a sample-history model plus directed literals.
module tb_stab_window_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en0 = 1'b0, trig0 = 1'b0, sig0 = 1'b0;
  logic       en1 = 1'b0, trig1 = 1'b0, sig1 = 1'b0;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [15:0] last0, fail0;
  logic [1:0]  last1, fail1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  stab_window_monitor u_dut0 (
    .clk(clk), .rst(rst), .en(en0), .trig(trig0), .sig_in(sig0),
    .busy(busy0), .done(done0), .pass(pass0), .last_settle(last0), .fail_cnt(fail0)
  );

  stab_window_monitor #(.DEADLINE(3), .STABLE_LEN(2), .CNT_W(2)) u_dut1 (
    .clk(clk), .rst(rst), .en(en1), .trig(trig1), .sig_in(sig1),
    .busy(busy1), .done(done1), .pass(pass1), .last_settle(last1), .fail_cnt(fail1)
  );

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  cfg_dl[2]   = '{64, 3};
  int  cfg_sl[2]   = '{8, 2};
  int  cfg_max[2]  = '{65535, 3};
  bit  m_active[2];
  int  m_k[2];
  bit  hist[2][0:127];
  bit  m_busy[2], m_done[2], m_pass[2];
  int  m_last[2], m_fail[2];

  task automatic model_step(input int i, input bit r, input bit e, input bit t, input bit s);
    int run;
    if (r) begin
      m_active[i] = 1'b0; m_busy[i] = 1'b0; m_done[i] = 1'b0; m_pass[i] = 1'b0;
      m_last[i] = 0; m_fail[i] = 0;
    end else begin
      m_done[i] = 1'b0;
      if (!m_active[i]) begin
        if (t && e) begin
          m_active[i] = 1'b1;
          m_k[i] = 0;
          hist[i][0] = s;
        end
      end else begin
        m_k[i]++;
        hist[i][m_k[i]] = s;
        // length of the trailing run of non-toggling samples in this check
        run = 0;
        for (int j = m_k[i]; j > 0; j--) begin
          if (hist[i][j] != hist[i][j-1]) break;
          run++;
        end
        if (!e) begin
          m_active[i] = 1'b0;
        end else if (run >= cfg_sl[i]) begin
          m_done[i] = 1'b1; m_pass[i] = 1'b1; m_last[i] = m_k[i]; m_active[i] = 1'b0;
        end else if (m_k[i] == cfg_dl[i]) begin
          m_done[i] = 1'b1; m_pass[i] = 1'b0; m_active[i] = 1'b0;
          if (m_fail[i] < cfg_max[i]) m_fail[i]++;
        end
      end
      m_busy[i] = m_active[i];
    end
  endtask

  // Per-cycle compare: sample inputs at the edge, advance the model, check #1 later
  initial begin
    bit r, e0, t0, s0, e1, t1, s1;
    forever begin
      @(posedge clk);
      r = rst; e0 = en0; t0 = trig0; s0 = sig0; e1 = en1; t1 = trig1; s1 = sig1;
      model_step(0, r, e0, t0, s0);
      model_step(1, r, e1, t1, s1);
      #1;
      check("i0_busy", int'(busy0), int'(m_busy[0]));
      check("i0_done", int'(done0), int'(m_done[0]));
      check("i0_pass", int'(pass0), int'(m_pass[0]));
      check("i0_last", int'(last0), m_last[0]);
      check("i0_fail", int'(fail0), m_fail[0]);
      check("i1_busy", int'(busy1), int'(m_busy[1]));
      check("i1_done", int'(done1), int'(m_done[1]));
      check("i1_pass", int'(pass1), int'(m_pass[1]));
      check("i1_last", int'(last1), m_last[1]);
      check("i1_fail", int'(fail1), m_fail[1]);
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic bit pat(input int mode, input int k);
    case (mode)
      0: return 1'b1;
      1: return (k < 3) ? 1'b1 : 1'b0;
      2: return 1'((k / 4) % 2);
      3: return (k < 56) ? 1'((k / 4) % 2) : 1'b0;
      default: return 1'(k % 2);
    endcase
  endfunction

  task automatic set_in(input int i, input bit e, input bit t, input bit s);
    if (i == 0) begin en0 = e; trig0 = t; sig0 = s; end
    else begin en1 = e; trig1 = t; sig1 = s; end
  endtask

  bit busy_at[0:127];

  // Caller is at least #1 past an edge; trig is sampled at the next edge (E0)
  task automatic run_check(input int i, input int mode, input int drop_k, input int bound,
                           output int done_k, output int got_pass);
    #1;
    set_in(i, 1'b1, 1'b1, pat(mode, 0));
    @(posedge clk);
    #2;
    set_in(i, (drop_k == 1) ? 1'b0 : 1'b1, 1'b0, pat(mode, 1));
    done_k = -1;
    got_pass = 0;
    for (int k = 1; k <= bound; k++) begin
      @(posedge clk);
      #1;
      busy_at[k] = (i == 0) ? busy0 : busy1;
      if (((i == 0) ? done0 : done1) == 1'b1) begin
        done_k = k;
        got_pass = int'((i == 0) ? pass0 : pass1);
        break;
      end
      #1;
      set_in(i, (k + 1 == drop_k) ? 1'b0 : 1'b1, 1'b0, pat(mode, k + 1));
    end
    if (done_k < 0 && drop_k == 0) check("verdict_timeout", 0, 1);
  endtask

  initial begin
    int dk, p;
    int exp_fail[5] = '{1, 2, 3, 3, 3};
    repeat (3) @(posedge clk);
    #2 rst = 1'b0; sig0 = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // constant input: pass at E8
    run_check(0, 0, 0, 70, dk, p);
    check("s1_done_k", dk, 8);
    check("s1_pass", p, 1);
    check("s1_last", int'(last0), 8);
    check("s1_busy_e1", int'(busy_at[1]), 1);
    check("s1_busy_e7", int'(busy_at[7]), 1);
    check("s1_busy_e8", int'(busy_at[8]), 0);

    // toggle at E3, back-to-back with the previous verdict
    run_check(0, 1, 0, 70, dk, p);
    check("s2_done_k", dk, 11);
    check("s2_last", int'(last0), 11);

    // toggles every 4 cycles: deadline failure
    run_check(0, 2, 0, 70, dk, p);
    check("s3_done_k", dk, 64);
    check("s3_pass", p, 0);
    check("s3_fail", int'(fail0), 1);

    // last toggle at E56: pass coincides with deadline
    run_check(0, 3, 0, 70, dk, p);
    check("s4_done_k", dk, 64);
    check("s4_pass", p, 1);
    check("s4_last", int'(last0), 64);
    check("s4_fail", int'(fail0), 1);

    // enable dropped at E5, then fresh trig sampled at E7
    run_check(0, 0, 5, 6, dk, p);
    check("s5_no_done", dk, -1);
    check("s5_busy_e4", int'(busy_at[4]), 1);
    check("s5_busy_e5", int'(busy_at[5]), 0);
    check("s5_last_kept", int'(last0), 64);
    run_check(0, 0, 0, 70, dk, p);
    check("s6_done_k", dk, 8);
    check("s6_pass", p, 1);

    // narrow instance: fail count saturates at 3
    for (int n = 0; n < 5; n++) begin
      run_check(1, 4, 0, 10, dk, p);
      check("s7_done_k", dk, 3);
      check("s7_pass", p, 0);
      check("s7_fail", int'(fail1), exp_fail[n]);
    end

    // reset mid-check on the narrow instance
    #1;
    set_in(1, 1'b1, 1'b1, 1'b1);
    @(posedge clk);
    #2;
    set_in(1, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("s8_busy", int'(busy1), 0);
    check("s8_done", int'(done1), 0);
    check("s8_pass", int'(pass1), 0);
    check("s8_last", int'(last1), 0);
    check("s8_fail", int'(fail1), 0);
    check("s8_last0", int'(last0), 0);
    #1 rst = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("s8_no_done", int'(done1), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stab_window_monitor.md
Name: stab_window_monitor

Overview:
- Downstream consumer of the single-bit shift-register delay buffer in the stabilization property monitor.
- On a trigger, it watches the buffered sample stream and decides whether the signal settles within a deadline.
- Settled means no toggles for STABLE_LEN consecutive cycles, reached within DEADLINE cycles.
- Emits a one-cycle verdict, the settle time, and a saturating failure count for the monitoring fabric.

Parameters:
- DEADLINE, 64, max SETTLE cycles allowed per check; 1 <= STABLE_LEN <= DEADLINE < 2^CNT_W
- STABLE_LEN, 8, consecutive non-toggling cycles required for pass
- CNT_W, 16, width of internal counters, last_settle and fail_cnt

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- en  in  1  monitor enable; deassertion aborts a running check
- trig  in  1  start-of-check request, sampled when idle
- sig_in  in  1  delayed sample from the shift-register buffer output
- busy  out  1  high while a check is in SETTLE
- done  out  1  one-cycle verdict strobe
- pass  out  1  verdict of last completed check; held until next done
- last_settle  out  CNT_W  SETTLE cycle index at which the last pass was declared
- fail_cnt  out  CNT_W  saturating count of failed checks

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset forces state IDLE, sig_q=0, elapsed=0, stable_cnt=0, busy=0, done=0, pass=0, last_settle=0, fail_cnt=0. Reset mid-check discards the check with no done.
- sig_q register: sig_q <= sig_in every cycle in every state. toggle = sig_in ^ sig_q (combinational).
- IDLE:
  - If trig && en at edge E0: go to SETTLE and clear elapsed and stable_cnt.
  - busy is registered and reads 1 from E0 onward.
  - trig without en is ignored.
- SETTLE, evaluated at each edge Ek (k = 1, 2, ...):
  - elapsed_n = elapsed + 1
  - stable_n = toggle ? 0 : stable_cnt + 1; stable_n saturates at STABLE_LEN.
  - If en == 0: go to IDLE, busy=0, no done, pass/last_settle/fail_cnt unchanged. Abort has priority over a verdict.
  - Else if stable_n == STABLE_LEN: go to IDLE, done=1, pass=1, last_settle=elapsed_n.
  - Else if elapsed_n == DEADLINE: go to IDLE, done=1, pass=0; fail_cnt += 1, saturating at 2^CNT_W-1.
  - Pass beats the deadline when both occur on the same edge.
- trig while in SETTLE is ignored; it is not queued.
- done is high for exactly one cycle, registered, after the verdict edge. busy falls on the same edge.
- A trig sampled while done=1 (state already IDLE) is accepted, giving back-to-back checks with no dead cycle.
- Latency: with constant sig_in, pass is declared at E_STABLE_LEN and last_settle = STABLE_LEN. The worst-case verdict is at E_DEADLINE.
- No combinational path from any input to any output.

Test Plan:
- Constant sig_in=1, default params, trig at E0 -> done=1, pass=1 after E8; last_settle=8; busy 1 from E0 through E7, 0 after E8.
- sig_in toggles sampled at E3, then constant -> stable_cnt=0 at E3; pass at E11; last_settle=11.
- sig_in toggles every 4 cycles -> no pass; done=1, pass=0 after E64; fail_cnt=1.
- Last toggle at E56, then constant -> pass and deadline coincide at E64; pass=1, last_settle=64, fail_cnt unchanged.
- en dropped at E5 during SETTLE -> busy=0 after E5; done never asserts; a new trig at E7 starts a fresh check.
- CNT_W=2, five consecutive failing checks -> fail_cnt sequence 1,2,3,3,3; rst mid-check -> all outputs 0 next cycle, no done.
